pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 139 +++++++++++++
 tb/tb_pc_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program counter controller: BOOT/RUN/HALT sequencing with trap, mret, branch and stall handling.
// Optional macro PC_MISALIGN_CHK_EN turns misaligned branch targets into traps and adds the misalign output.
//
// state | meaning
// BOOT  | one settling cycle after reset, pc held, no fetch
// RUN   | fetching; requests resolved trap > mret > branch > halt > stall > pc+4
// HALT  | debug halt, pc held, only resume is honoured
module pc_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_req,
    input  logic        mret,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        fetch_valid,
    output logic        redirect,
`ifdef PC_MISALIGN_CHK_EN
    output logic        misalign,
`endif
    output logic [1:0]  state
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_redirect;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_epc_nxt;
    logic        w_redirect_nxt;
    logic        w_misalign_nxt;
    logic        w_to_halt;
    logic        w_br_misaligned;
    logic [31:0] w_br_tgt;
    logic [31:0] w_mret_tgt;

`ifdef PC_MISALIGN_CHK_EN
    logic        r_misalign;
    assign w_br_misaligned = (br_target[1:0] != 2'b00);
    assign w_br_tgt        = br_target;
    assign w_mret_tgt      = r_epc;
    assign misalign        = r_misalign;
`else
    // Without the checker, targets are silently word-aligned.
    assign w_br_misaligned = 1'b0;
    assign w_br_tgt        = br_target & ~32'h3;
    assign w_mret_tgt      = r_epc & ~32'h3;
`endif

    assign w_to_halt = halt_req & ~trap_req & ~mret & ~br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (w_to_halt) w_state_nxt = S_HALT;
            S_HALT:  if (resume) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_redirect_nxt = 1'b0;
        w_misalign_nxt = 1'b0;
        fetch_valid    = 1'b0;
        if (r_state == S_RUN) begin
            fetch_valid = ~w_to_halt & ~rst;
            if (trap_req) begin
                w_epc_nxt      = r_pc;
                w_pc_nxt       = TRAP_VEC;
                w_redirect_nxt = 1'b1;
            end else if (mret) begin
                w_pc_nxt       = w_mret_tgt;
                w_redirect_nxt = 1'b1;
            end else if (br_taken) begin
                w_redirect_nxt = 1'b1;
                if (w_br_misaligned) begin
                    w_epc_nxt      = r_pc;
                    w_pc_nxt       = TRAP_VEC;
                    w_misalign_nxt = 1'b1;
                end else begin
                    w_pc_nxt = w_br_tgt;
                end
            end else if (!halt_req && !stall) begin
                w_pc_nxt = r_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_VEC;
            r_epc      <= RESET_VEC;
            r_redirect <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_redirect <= w_redirect_nxt;
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= w_misalign_nxt;
    end
`else
    logic w_misalign_unused;
    assign w_misalign_unused = w_misalign_nxt;
`endif

    assign pc       = r_pc;
    assign epc      = r_epc;
    assign redirect = r_redirect;
    assign state    = r_state;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: reset/boot, branch vs stall, trap/mret, wrap, halt/resume, misaligned branch.
module tb_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_req;
    logic        mret;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        fetch_valid;
    logic        redirect;
    logic [1:0]  state;
`ifdef PC_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int n_total = 0;
    int n_bad   = 0;

    pc_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap_req    (trap_req),
        .mret        (mret),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc          (pc),
        .epc         (epc),
        .fetch_valid (fetch_valid),
        .redirect    (redirect),
`ifdef PC_MISALIGN_CHK_EN
        .misalign    (misalign),
`endif
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; br_taken = 0; br_target = 0; trap_req = 0;
        mret = 0; halt_req = 0; resume = 0;
    endtask

    task automatic branch(input logic [31:0] tgt);
        br_taken = 1; br_target = tgt;
        tick();
        clr();
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_redir", {31'd0, redirect}, 32'd0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);

        // Release: one BOOT cycle at pc=0, then RUN at pc=0, then 4, 8, 12
        rst = 0;
        trap_req = 1;
        chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
        chk("boot_pc", pc, 32'h0);
        tick();
        trap_req = 0;
        chk("run0_state", {30'd0, state}, 32'd1);
        chk("run0_pc", pc, 32'h0);
        chk("run0_fv", {31'd0, fetch_valid}, 32'd1);
        chk("run0_epc", epc, 32'h0);
        tick(); chk("seq4", pc, 32'h4);
        tick(); chk("seq8", pc, 32'h8);
        tick(); chk("seq12", pc, 32'hC);
        chk("seq_redir", {31'd0, redirect}, 32'd0);
        tick(); chk("seq16", pc, 32'h10);

        // Branch overrides simultaneous stall
        stall = 1; br_taken = 1; br_target = 32'h40;
        tick();
        clr();
        chk("brst_pc", pc, 32'h40);
        chk("brst_redir", {31'd0, redirect}, 32'd1);
        tick();
        chk("brst_pc2", pc, 32'h44);
        chk("brst_redir2", {31'd0, redirect}, 32'd0);

        // Stall alone holds
        stall = 1;
        tick(); chk("stall_pc", pc, 32'h44);
        clr();

        // Trap beats branch; mret returns
        branch(32'h20);
        chk("br20_pc", pc, 32'h20);
        trap_req = 1; br_taken = 1; br_target = 32'h80;
        tick();
        clr();
        chk("trap_pc", pc, 32'h100);
        chk("trap_epc", epc, 32'h20);
        chk("trap_redir", {31'd0, redirect}, 32'd1);
        tick();
        chk("trap_seq", pc, 32'h104);
        mret = 1; br_taken = 1; br_target = 32'h80;
        tick();
        clr();
        chk("mret_pc", pc, 32'h20);
        chk("mret_epc", epc, 32'h20);
        chk("mret_redir", {31'd0, redirect}, 32'd1);

        // Wrap at top of address space
        branch(32'hFFFF_FFFC);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", pc, 32'h0);

        // Halt / resume
        branch(32'h30);
        halt_req = 1;
        #1;
        chk("halt_fv_leave", {31'd0, fetch_valid}, 32'd0);
        tick();
        clr();
        chk("halt_state", {30'd0, state}, 32'd2);
        chk("halt_pc", pc, 32'h30);
        br_taken = 1; br_target = 32'h80; trap_req = 1; mret = 1;
        #1;
        chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        clr();
        chk("halt_hold_pc", pc, 32'h30);
        chk("halt_hold_epc", epc, 32'h20);
        chk("halt_redir", {31'd0, redirect}, 32'd0);
        resume = 1;
        tick();
        clr();
        chk("resume_state", {30'd0, state}, 32'd1);
        chk("resume_pc", pc, 32'h30);
        tick();
        chk("resume_seq", pc, 32'h34);
        resume = 1;
        tick();
        clr();
        chk("resume_run_ign", pc, 32'h38);
        chk("resume_run_st", {30'd0, state}, 32'd1);

        // Misaligned branch
        branch(32'h42);
`ifdef PC_MISALIGN_CHK_EN
        chk("mis_pc", pc, 32'h100);
        chk("mis_epc", epc, 32'h38);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
`else
        chk("mis_pc", pc, 32'h40);
        chk("mis_epc", epc, 32'h20);
`endif
        chk("mis_redir", {31'd0, redirect}, 32'd1);
        tick();
`ifdef PC_MISALIGN_CHK_EN
        chk("mis_flag_clr", {31'd0, misalign}, 32'd0);
`endif
        chk("mis_redir_clr", {31'd0, redirect}, 32'd0);

        // Reset during HALT
        halt_req = 1;
        tick();
        clr();
        chk("h2_state", {30'd0, state}, 32'd2);
        rst = 1; resume = 1;
        tick();
        clr();
        chk("hrst_state", {30'd0, state}, 32'd0);
        chk("hrst_pc", pc, 32'h0);
        chk("hrst_epc", epc, 32'h0);
        chk("hrst_fv", {31'd0, fetch_valid}, 32'd0);
        rst = 0;
        tick();
        chk("hrst_run", {30'd0, state}, 32'd1);
        chk("hrst_run_pc", pc, 32'h0);
        tick();
        chk("hrst_seq", pc, 32'h4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
